// File: rtl/cva6_sq_pkg.sv
// Shared types and constants for the store-queue model.
//   entry_state_e : per-entry lifecycle encoding (2'b10 is never produced)
//   ERR_*         : bit positions inside err_o
//   OFFS_*        : page-offset slice used by the load alias check
package cva6_sq_pkg;

    typedef enum logic [1:0] {
        FREE      = 2'b00,
        COMMITTED = 2'b01,
        SPEC      = 2'b11
    } entry_state_e;

    localparam int unsigned ERR_OVERFLOW = 0;
    localparam int unsigned ERR_SERVE    = 1;
    localparam int unsigned ERR_COMMIT   = 2;

    localparam int unsigned OFFS_HI = 11;
    localparam int unsigned OFFS_LO = 3;
    localparam int unsigned OFFS_W  = OFFS_HI - OFFS_LO + 1;

endpackage

// File: rtl/cva6_sq_offset_match.sv
// DEPTH-way page-offset alias compare.
//   stage_valid_i / stage_offs_i : staged store and its offset slice
//   entry_busy_i                 : per-entry non-FREE flag
//   entry_offs_i                 : per-entry offset slices, entry i at [i*OFFS_W +: OFFS_W]
//   page_offset_i                : load page offset
//   match_o                      : any live store aliases the load offset
module cva6_sq_offset_match
    import cva6_sq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    stage_valid_i,
    input  logic [OFFS_W-1:0]       stage_offs_i,
    input  logic [DEPTH-1:0]        entry_busy_i,
    input  logic [DEPTH*OFFS_W-1:0] entry_offs_i,
    input  logic [11:0]             page_offset_i,
    output logic                    match_o
);

    logic [OFFS_W-1:0] load_offs;
    logic [DEPTH-1:0]  hit;

    assign load_offs = page_offset_i[OFFS_HI:OFFS_LO];

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = entry_busy_i[i] && (entry_offs_i[i*OFFS_W +: OFFS_W] == load_offs);
        end
    end

    assign match_o = (stage_valid_i && (stage_offs_i == load_offs)) || (|hit);

endmodule

// File: rtl/cva6_store_queue_model.sv
// Cycle-level reference model of the CVA6 store queue.
//   instr_i / instr_valid_i : store issue, registered into a stage before allocation
//   commit_i                : promote oldest SPEC entry to COMMITTED
//   store_mem_resp_i        : free oldest COMMITTED entry
//   flush_i                 : drop all SPEC entries and the staged store
//   page_offset_i / page_offset_matches_o : load alias check on offset [11:3]
//   ready_o, empty_o, count_o, state_o    : occupancy view of the current state
//   err_o                   : sticky {commit_err, serve_err, overflow}
module cva6_store_queue_model
    import cva6_sq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [INSTR_W-1:0]       instr_i,
    input  logic                     instr_valid_i,
    input  logic                     commit_i,
    input  logic                     store_mem_resp_i,
    input  logic                     flush_i,
    input  logic [11:0]              page_offset_i,
    output logic                     page_offset_matches_o,
    output logic                     ready_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [2*DEPTH-1:0]       state_o,
    output logic [2:0]               err_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    entry_state_e       state_q [DEPTH];
    entry_state_e       state_d [DEPTH];
    logic [INSTR_W-1:0] word_q  [DEPTH];
    logic [INSTR_W-1:0] word_d  [DEPTH];
    logic [PC_W-1:0]    tag_q   [DEPTH];
    logic [PC_W-1:0]    tag_d   [DEPTH];

    logic [PtrW-1:0]    store_ptr_q, store_ptr_d;
    logic [PtrW-1:0]    commit_ptr_q, commit_ptr_d;
    logic [PtrW-1:0]    serve_ptr_q, serve_ptr_d;
    logic [PC_W-1:0]    tag_cnt_q, tag_cnt_d;
    logic               stage_valid_q, stage_valid_d;
    logic [INSTR_W-1:0] stage_word_q, stage_word_d;
    logic [2:0]         err_q, err_d;

    logic [DEPTH-1:0]        entry_busy;
    logic [DEPTH*OFFS_W-1:0] entry_offs;
    logic [CntW-1:0]         count;

    // Next state. Every condition looks at pre-edge state only; the three
    // updated entries are distinct because their required states differ.
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        tag_d         = tag_q;
        store_ptr_d   = store_ptr_q;
        commit_ptr_d  = commit_ptr_q;
        serve_ptr_d   = serve_ptr_q;
        tag_cnt_d     = tag_cnt_q;
        err_d         = err_q;
        stage_valid_d = flush_i ? 1'b0 : instr_valid_i;
        stage_word_d  = instr_i;

        if (store_mem_resp_i) begin
            if (state_q[serve_ptr_q] == COMMITTED) begin
                state_d[serve_ptr_q] = FREE;
                serve_ptr_d          = serve_ptr_q + PtrW'(1);
            end else begin
                err_d[ERR_SERVE] = 1'b1;
            end
        end

        if (flush_i) begin
            // Commit is ignored and the staged store is dropped silently.
            for (int i = 0; i < DEPTH; i++) begin
                if (state_q[i] == SPEC) state_d[i] = FREE;
            end
            store_ptr_d = commit_ptr_q;
        end else begin
            if (commit_i) begin
                if (state_q[commit_ptr_q] == SPEC) begin
                    state_d[commit_ptr_q] = COMMITTED;
                    commit_ptr_d          = commit_ptr_q + PtrW'(1);
                end else begin
                    err_d[ERR_COMMIT] = 1'b1;
                end
            end
            if (stage_valid_q) begin
                if (state_q[store_ptr_q] == FREE) begin
                    state_d[store_ptr_q] = SPEC;
                    word_d[store_ptr_q]  = stage_word_q;
                    tag_d[store_ptr_q]   = tag_cnt_q;
                    store_ptr_d          = store_ptr_q + PtrW'(1);
                    tag_cnt_d            = tag_cnt_q + PC_W'(1);
                end else begin
                    err_d[ERR_OVERFLOW] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= FREE;
                word_q[i]  <= '0;
                tag_q[i]   <= '0;
            end
            store_ptr_q   <= '0;
            commit_ptr_q  <= '0;
            serve_ptr_q   <= '0;
            tag_cnt_q     <= '0;
            stage_valid_q <= 1'b0;
            stage_word_q  <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            tag_q         <= tag_d;
            store_ptr_q   <= store_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            serve_ptr_q   <= serve_ptr_d;
            tag_cnt_q     <= tag_cnt_d;
            stage_valid_q <= stage_valid_d;
            stage_word_q  <= stage_word_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        entry_busy = '0;
        entry_offs = '0;
        state_o    = '0;
        count      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_busy[i]                    = (state_q[i] != FREE);
            entry_offs[i*OFFS_W +: OFFS_W]   = word_q[i][OFFS_HI:OFFS_LO];
            state_o[2*i +: 2]                = state_q[i];
            if (state_q[i] != FREE) count = count + CntW'(1);
        end
    end

    assign ready_o = (state_q[store_ptr_q] == FREE);
    assign empty_o = (count == '0) && !stage_valid_q;
    assign count_o = count;
    assign err_o   = err_q;

    cva6_sq_offset_match #(
        .DEPTH (DEPTH)
    ) u_offset_match (
        .stage_valid_i (stage_valid_q),
        .stage_offs_i  (stage_word_q[OFFS_HI:OFFS_LO]),
        .entry_busy_i  (entry_busy),
        .entry_offs_i  (entry_offs),
        .page_offset_i (page_offset_i),
        .match_o       (page_offset_matches_o)
    );

endmodule

// File: tb/tb_cva6_store_queue_model.sv
module tb_cva6_store_queue_model;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        commit_i = 1'b0;
    logic        store_mem_resp_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [11:0] page_offset_i = '0;
    logic        page_offset_matches_o;
    logic        ready_o;
    logic        empty_o;
    logic [2:0]  count_o;
    logic [7:0]  state_o;
    logic [2:0]  err_o;

    int n_cmp = 0;
    int n_bad = 0;

    cva6_store_queue_model #(
        .DEPTH   (4),
        .INSTR_W (32),
        .PC_W    (8)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .instr_i               (instr_i),
        .instr_valid_i         (instr_valid_i),
        .commit_i              (commit_i),
        .store_mem_resp_i      (store_mem_resp_i),
        .flush_i               (flush_i),
        .page_offset_i         (page_offset_i),
        .page_offset_matches_o (page_offset_matches_o),
        .ready_o               (ready_o),
        .empty_o               (empty_o),
        .count_o               (count_o),
        .state_o               (state_o),
        .err_o                 (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one active edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic c, input logic r,
                         input logic f);
        instr_valid_i    = v;
        instr_i          = w;
        commit_i         = c;
        store_mem_resp_i = r;
        flush_i          = f;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        page_offset_i = '0;
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_ready", ready_o, 1);
        check("rst_empty", empty_o, 1);
        check("rst_count", count_o, 0);
        check("rst_state", state_o, 0);
        check("rst_match", page_offset_matches_o, 0);
        check("rst_err", err_o, 0);
        rst_ni = 1'b1;
        tick();

        // Fill all four entries, then overflow.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + i * 8, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("full_state", state_o, 8'hFF);
        check("full_count", count_o, 4);
        check("full_ready", ready_o, 0);
        check("full_err", err_o, 0);
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("ovf_err", err_o, 3'b001);
        check("ovf_state", state_o, 8'hFF);

        // Mid-operation reset with a staged store in flight.
        drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        tick();
        do_reset();
        check("mrst_empty", empty_o, 1);
        check("mrst_err", err_o, 0);
        check("mrst_state", state_o, 0);

        // Issue A, B; commit twice; serve twice.
        drive(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0,  1'b0, 1'b0, 1'b0); tick();
        check("ab_state", state_o, 8'h0F);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick(); tick();
        check("ab_commit", state_o, 8'h05);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick(); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("ab_state0", state_o, 0);
        check("ab_empty", empty_o, 1);
        check("ab_err", err_o, 0);
        check("ab_serve_ptr", dut.serve_ptr_q, 2);

        // Three stores, commit one, flush.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + i * 8, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
        // commit_i held high during flush must be ignored without error
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("fl_state", state_o, 8'h01);
        check("fl_count", count_o, 1);
        check("fl_store_ptr", dut.store_ptr_q, 1);
        check("fl_err", err_o, 0);
        drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0,   1'b0, 1'b0, 1'b0); tick();
        check("fl_realloc", state_o, 8'h0D);
        check("fl_tag", dut.tag_q[1], 3);

        // Serve on a SPEC head, then commit on an empty queue.
        do_reset();
        drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0,   1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0,   1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
        check("serr_err", err_o, 3'b010);
        check("serr_state", state_o, 8'h03);
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("cerr_err", err_o, 3'b100);
        check("cerr_state", state_o, 0);

        // Page-offset alias check.
        do_reset();
        drive(1'b1, 32'h0000_0A48, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        page_offset_i = 12'hA4F; #1;
        check("m_staged", page_offset_matches_o, 1);
        page_offset_i = 12'hA50; #1;
        check("m_staged_miss", page_offset_matches_o, 0);
        tick();
        page_offset_i = 12'hA4F; #1;
        check("m_queued", page_offset_matches_o, 1);
        page_offset_i = 12'hA50; #1;
        check("m_queued_miss", page_offset_matches_o, 0);
        page_offset_i = 12'hA4F;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
        check("m_committed", page_offset_matches_o, 1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("m_served", page_offset_matches_o, 0);

        // Pipelined issue/commit/serve across pointer wrap.
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            drive(c <= 10, 32'h700 + c * 8, (c >= 3) && (c <= 12), (c >= 4), 1'b0);
            tick();
            if (c >= 2 && c <= 11) check("wr_tag", dut.tag_q[(c - 2) % 4], c - 2);
            if (c >= 4 && c <= 11) check("wr_count", count_o, 2);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("wr_err", err_o, 0);
        check("wr_empty", empty_o, 1);
        check("wr_state", state_o, 0);
        check("wr_serve_ptr", dut.serve_ptr_q, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
